inst_cache_direct: RTL and testbench
====================================

Name: inst_cache_direct

Overview:
- Direct-mapped, read-only instruction cache between the IF stage's instruction-memory interface and the memory/bus read port.
- Accepts one fetch address at a time via valid/ready.
- On a hit, returns the 32-bit instruction from its line arrays.
- On a miss, issues one line-aligned burst read, refills the line, then returns the requested word.

Parameters:
- LINE_WORDS, 8, 32-bit words per line (power of 2); line = 32 B at default.
- SETS, 8, number of lines (power of 2).
- Address split at default: offset = addr[4:2], index = addr[7:5], tag = addr[31:8]. addr[1:0] is ignored.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- from_cpu_inst_req_valid  in  1  fetch request valid.
- from_cpu_inst_req_addr  in  32  fetch address (PC).
- to_cpu_inst_req_ready  out  1  cache accepts request.
- to_cpu_cache_rsp_valid  out  1  instruction valid.
- to_cpu_cache_rsp_data  out  32  instruction word.
- from_cpu_cache_rsp_ready  in  1  CPU accepts instruction.
- to_mem_rd_req_valid  out  1  line read request valid.
- to_mem_rd_req_addr  out  32  line-aligned read address.
- from_mem_rd_req_ready  in  1  memory accepts request.
- from_mem_rd_rsp_valid  in  1  refill beat valid.
- from_mem_rd_rsp_data  in  32  refill beat data.
- from_mem_rd_rsp_last  in  1  final beat of burst.
- to_mem_rd_rsp_ready  out  1  cache accepts beat.

Behaviour:
- Reset (async): state = IDLE, all valid bits = 0, beat counter = 0, every output = 0 except to_cpu_inst_req_ready.
- to_cpu_inst_req_ready is 1 from the first clock edge after reset deassertion.
- Tag and data arrays are not reset.
- FSM states: IDLE, LOOKUP, MEM_REQ, REFILL, RESP (one-hot).
- IDLE:
  - to_cpu_inst_req_ready = 1.
  - On valid & ready, latch the address into req_addr and go to LOOKUP.
  - No other state asserts ready.
- LOOKUP:
  - hit = valid[index] && tag_array[index] == req tag.
  - hit -> RESP; miss -> MEM_REQ.
- MEM_REQ:
  - to_mem_rd_req_valid = 1 and to_mem_rd_req_addr = {req tag, index, offset bits = 0}.
  - Address is held stable until from_mem_rd_req_ready, then go to REFILL with beat counter = 0.
- REFILL:
  - to_mem_rd_rsp_ready = 1.
  - On each valid beat, write data into data[index][beat counter] and increment the counter (wraps mod LINE_WORDS).
  - On a beat with last = 1: set valid[index] = 1 and tag_array[index] = req tag, then go to RESP.
  - valid[index] is cleared on MEM_REQ entry, so a partially refilled line is never a hit.
- RESP:
  - to_cpu_cache_rsp_valid = 1 and to_cpu_cache_rsp_data = data[index][offset], held stable until from_cpu_cache_rsp_ready.
  - Then go to IDLE.
- Latency:
  - Hit: request accepted at edge N, rsp_valid high in cycle N+2.
  - Miss: MEM_REQ in cycle N+2; RESP the cycle after the last beat.
- The memory side delivers exactly LINE_WORDS beats with last on the final beat. A gap-free burst (no cycles with rsp_valid low) needs no extra stall.
- The same address, or a different word of the same line, issued immediately after a refill must hit.
- Conflict (same index, different tag) evicts the old line; there is no writeback (read-only).
- rst asserted mid-REFILL or mid-RESP:
  - Immediate return to IDLE with all lines invalid and no response delivered.
  - Remaining in-flight beats are not accepted (rsp_ready = 0).
  - The memory side is reset by the same rst.
- The array write from a beat and the RESP read happen in different cycles, so there is no read/write collision.

Test Plan:
- Cold miss: reset, request addr 0x0000_0004. Required:
  - mem req addr = 0x0000_0000.
  - Feed beats 0x11..0x18 with last on the 8th.
  - rsp_data = 0x12 the cycle after the last beat.
- Hit after refill: then request 0x0000_001C -> rsp_valid two cycles after acceptance, data 0x18, no mem request.
- Conflict eviction: request 0x0000_0100 (index 0, new tag) -> mem req 0x0000_0100, refill; then 0x0000_0004 misses again and refills from 0x0000_0000.
- Backpressure:
  - Hold from_mem_rd_req_ready = 0 for 5 cycles -> req_valid/addr stable throughout.
  - Hold from_cpu_cache_rsp_ready = 0 for 3 cycles -> rsp_valid/data stable, req_ready = 0.
- Gapped burst: insert rsp_valid = 0 bubbles between beats -> line contents correct, RESP only after last.
- Reset mid-refill: assert rst after beat 3 -> outputs zero asynchronously; re-request same addr -> full miss and refill.

Source files
------------

// File: rtl/inst_cache_direct.sv
// inst_cache_direct: direct-mapped read-only instruction cache with line-burst refill.
// One fetch in flight; a miss refills the whole line before the requested word is returned.
module inst_cache_direct #(
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - OW - IW;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_LOOKUP  = 5'b00010,
        S_MEM_REQ = 5'b00100,
        S_REFILL  = 5'b01000,
        S_RESP    = 5'b10000
    } state_t;

    state_t          r_state, w_next;
    logic            r_live;
    logic [31:2]     r_req_addr;
    logic [SETS-1:0] r_valid;
    logic [OW-1:0]   r_beat;
    logic [TW-1:0]   r_tag [SETS];
    logic [31:0]     r_data [SETS*LINE_WORDS];

    logic [OW-1:0] w_off;
    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_hit, w_accept, w_beat, w_unused;

    assign w_unused = ^from_cpu_inst_req_addr[1:0];
    assign w_off    = r_req_addr[OW+1:2];
    assign w_idx    = r_req_addr[OW+IW+1:OW+2];
    assign w_tag    = r_req_addr[31:OW+IW+2];
    assign w_hit    = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign w_accept = to_cpu_inst_req_ready && from_cpu_inst_req_valid;
    assign w_beat   = r_state == S_REFILL && from_mem_rd_rsp_valid;

    // r_live keeps ready low until the first edge after reset release
    assign to_cpu_inst_req_ready  = r_state == S_IDLE && r_live;
    assign to_cpu_cache_rsp_valid = r_state == S_RESP;
    assign to_cpu_cache_rsp_data  = r_state == S_RESP ? r_data[{w_idx, w_off}] : 32'h0;
    assign to_mem_rd_req_valid    = r_state == S_MEM_REQ;
    assign to_mem_rd_req_addr     = r_state == S_MEM_REQ ? {r_req_addr[31:OW+2], {(OW+2){1'b0}}} : 32'h0;
    assign to_mem_rd_rsp_ready    = r_state == S_REFILL;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_accept ? S_LOOKUP : S_IDLE;
            S_LOOKUP:  w_next = w_hit ? S_RESP : S_MEM_REQ;
            S_MEM_REQ: w_next = from_mem_rd_req_ready ? S_REFILL : S_MEM_REQ;
            S_REFILL:  w_next = w_beat && from_mem_rd_rsp_last ? S_RESP : S_REFILL;
            S_RESP:    w_next = from_cpu_cache_rsp_ready ? S_IDLE : S_RESP;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_live     <= 1'b0;
            r_req_addr <= '0;
            r_valid    <= '0;
            r_beat     <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept)
                r_req_addr <= from_cpu_inst_req_addr[31:2];
            // invalidate on miss so a partially refilled line can never hit
            if (r_state == S_LOOKUP && !w_hit)
                r_valid[w_idx] <= 1'b0;
            if (w_beat && from_mem_rd_rsp_last)
                r_valid[w_idx] <= 1'b1;
            if (r_state == S_MEM_REQ)
                r_beat <= '0;
            else if (w_beat)
                r_beat <= r_beat + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat)
            r_data[{w_idx, r_beat}] <= from_mem_rd_rsp_data;
        if (w_beat && from_mem_rd_rsp_last)
            r_tag[w_idx] <= w_tag;
    end
endmodule

// File: tb/tb_inst_cache_direct.sv
// tb_inst_cache_direct: directed fetch sequences with hand-computed expected words.
// Inputs are driven and outputs sampled on the falling edge.
module tb_inst_cache_direct;
    logic        clk = 1'b0;
    logic        rst;
    logic        from_cpu_inst_req_valid;
    logic [31:0] from_cpu_inst_req_addr;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;

    int n_vec = 0;
    int n_err = 0;

    inst_cache_direct dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one fetch; on a miss the line is served as base+0 .. base+7
    task automatic fetch(input logic [31:0] addr, input bit miss, input logic [31:0] base,
                         input logic [31:0] exp, input int mstall, input int cstall, input bit gaps);
        chk("req_ready_idle", {31'b0, to_cpu_inst_req_ready}, 32'd1);
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = addr;
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b0;
        chk("req_ready_lookup", {31'b0, to_cpu_inst_req_ready}, 32'd0);
        chk("rsp_valid_lookup", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
        @(negedge clk);
        if (miss) begin
            chk("rsp_valid_memreq", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
            for (int i = 0; i < mstall; i++) begin
                chk("mem_valid_stall", {31'b0, to_mem_rd_req_valid}, 32'd1);
                chk("mem_addr_stall", to_mem_rd_req_addr, addr & ~32'h1f);
                @(negedge clk);
            end
            chk("mem_valid", {31'b0, to_mem_rd_req_valid}, 32'd1);
            chk("mem_addr", to_mem_rd_req_addr, addr & ~32'h1f);
            from_mem_rd_req_ready = 1'b1;
            @(negedge clk);
            from_mem_rd_req_ready = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (gaps && i % 2 == 1) begin
                    from_mem_rd_rsp_valid = 1'b0;
                    @(negedge clk);
                    chk("rsp_valid_gap", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
                end
                from_mem_rd_rsp_valid = 1'b1;
                from_mem_rd_rsp_data  = base + i;
                from_mem_rd_rsp_last  = (i == 7);
                chk("mem_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd1);
                @(negedge clk);
            end
            from_mem_rd_rsp_valid = 1'b0;
            from_mem_rd_rsp_last  = 1'b0;
        end else begin
            chk("mem_valid_hit", {31'b0, to_mem_rd_req_valid}, 32'd0);
        end
        for (int i = 0; i < cstall; i++) begin
            chk("rsp_valid_stall", {31'b0, to_cpu_cache_rsp_valid}, 32'd1);
            chk("rsp_data_stall", to_cpu_cache_rsp_data, exp);
            chk("req_ready_stall", {31'b0, to_cpu_inst_req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("rsp_valid", {31'b0, to_cpu_cache_rsp_valid}, 32'd1);
        chk("rsp_data", to_cpu_cache_rsp_data, exp);
        from_cpu_cache_rsp_ready = 1'b1;
        @(negedge clk);
        from_cpu_cache_rsp_ready = 1'b0;
        chk("rsp_valid_done", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        from_cpu_inst_req_valid  = 1'b0;
        from_cpu_inst_req_addr   = '0;
        from_cpu_cache_rsp_ready = 1'b0;
        from_mem_rd_req_ready    = 1'b0;
        from_mem_rd_rsp_valid    = 1'b0;
        from_mem_rd_rsp_data     = '0;
        from_mem_rd_rsp_last     = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
        chk("rst_rsp_data", to_cpu_cache_rsp_data, 32'd0);
        chk("rst_mem_valid", {31'b0, to_mem_rd_req_valid}, 32'd0);
        chk("rst_mem_addr", to_mem_rd_req_addr, 32'd0);
        chk("rst_mem_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h0000_0004, 1'b1, 32'h11, 32'h12, 0, 0, 1'b0);
        fetch(32'h0000_001C, 1'b0, 32'h0,  32'h18, 0, 0, 1'b0);
        fetch(32'h0000_0100, 1'b1, 32'h21, 32'h21, 5, 0, 1'b0);
        fetch(32'h0000_0004, 1'b1, 32'h31, 32'h32, 0, 3, 1'b0);
        fetch(32'h0000_0010, 1'b0, 32'h0,  32'h35, 0, 0, 1'b0);
        fetch(32'h0000_0048, 1'b1, 32'h41, 32'h43, 0, 0, 1'b1);
        fetch(32'h0000_005C, 1'b0, 32'h0,  32'h48, 0, 0, 1'b0);
        fetch(32'h0000_0044, 1'b0, 32'h0,  32'h42, 0, 0, 1'b0);

        // abort a refill after three beats with an asynchronous reset
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = 32'h0000_008C;
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b0;
        @(negedge clk);
        chk("abort_mem_addr", to_mem_rd_req_addr, 32'h0000_0080);
        from_mem_rd_req_ready = 1'b1;
        @(negedge clk);
        from_mem_rd_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            from_mem_rd_rsp_valid = 1'b1;
            from_mem_rd_rsp_data  = 32'h90 + i;
            @(negedge clk);
        end
        from_mem_rd_rsp_data = 32'h93;
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd0);
        chk("abort_rsp_valid", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
        chk("abort_rsp_data", to_cpu_cache_rsp_data, 32'd0);
        chk("abort_mem_valid", {31'b0, to_mem_rd_req_valid}, 32'd0);
        @(negedge clk);
        from_mem_rd_rsp_valid = 1'b0;
        chk("abort_rsp_valid_held", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h0000_008C, 1'b1, 32'h51, 32'h54, 0, 0, 1'b0);
        fetch(32'h0000_0004, 1'b1, 32'h61, 32'h62, 0, 0, 1'b0);
        fetch(32'h0000_0088, 1'b0, 32'h0,  32'h53, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
